mem_cmd_sequencer: RTL and testbench
====================================

Name: mem_cmd_sequencer

Overview:
Upstream command stage for the single-port memory block. It accepts write/read commands over a valid/ready handshake and buffers them in a small FIFO. It drives them in order onto the memory's enable/address/data pins, then captures read data after the memory's fixed latency and returns it over a valid/ready response channel.

Parameters:
ADDR_WIDTH, 8, memory address width
DATA_WIDTH, 32, memory data width
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
RD_LATENCY, 1, cycles from read issue (o_EN=0, address driven) to valid i_data_out

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when valid&ready
i_cmd_wr  in  1  1=write, 0=read
i_cmd_addr  in  ADDR_WIDTH  command address
i_cmd_data  in  DATA_WIDTH  write data (ignored for reads)
o_EN  out  1  memory write enable (1=write, 0=read/idle)
o_address  out  ADDR_WIDTH  memory address
o_data_in  out  DATA_WIDTH  memory write data
i_data_out  in  DATA_WIDTH  memory read data
o_rsp_valid  out  1  read response valid
i_rsp_ready  in  1  response consumer ready
o_rsp_data  out  DATA_WIDTH  read response data
o_busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, i_rst=1): FIFO flushed, FSM->IDLE; o_EN=0, o_address=0, o_data_in=0, o_rsp_valid=0, o_rsp_data=0, o_busy=0, o_cmd_ready=1 after reset deasserts. Reset mid-operation discards every queued/in-flight command; no response is produced for it.
- FIFO: push on i_cmd_valid&o_cmd_ready; o_cmd_ready = !full (registered-count based, no same-cycle pass-through when full). Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
- Push and pop in the same cycle: count unchanged, both take effect.
- FSM states: IDLE, WR, RD_WAIT, RSP.
- IDLE: if FIFO non-empty, pop head; write -> WR, read -> RD_WAIT. If empty, o_EN=0, address/data hold last values.
- WR: o_EN=1, o_address/o_data_in = popped entry for exactly one cycle. If FIFO non-empty, pop the next entry in the same cycle and go directly to WR or RD_WAIT, so back-to-back writes issue one per cycle. Otherwise go to IDLE.
- RD_WAIT: o_EN=0, o_address held, counter counts RD_LATENCY cycles. On the final cycle, capture i_data_out into o_rsp_data -> RSP.
- RSP: o_rsp_valid=1, o_rsp_data stable until i_rsp_ready=1. On the handshake, o_rsp_valid drops next cycle -> IDLE. No new command issues while in RSP (strict ordering, one outstanding read).
- Latency: write accepted into an empty FIFO appears on o_EN 1 cycle after acceptance (IDLE pop) and 2 cycles in total at the memory edge. A read gives o_rsp_valid 2+RD_LATENCY cycles after acceptance.
- o_EN is never 1 outside WR.

Optional Feature:
MEM_SEQ_CNT_EN defined: adds outputs o_wr_count and o_rd_count (16 bits each), cleared by reset. They increment on each WR cycle and each RSP handshake respectively, and saturate at 16'hFFFF.
Not defined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset mid-stream: queue 3 writes, assert i_rst during the second WR -> o_EN=0 immediately; after release o_busy=0, o_cmd_ready=1, no further writes.
- Write then read: write addr 1 data 1, write addr 2 data 2, read addr 1 (memory model returns 1) -> o_EN pulses 1 at addr 1 then addr 2 on consecutive cycles, o_rsp_valid=1 with o_rsp_data=1.
- Full FIFO: hold i_rsp_ready=0 with a read at the head, push 4 more commands -> o_cmd_ready=0 after the 4th accept. Push ignored while full; a 5th accept succeeds the cycle after a pop.
- Response backpressure: read addr 2 (data 2), hold i_rsp_ready=0 for 5 cycles -> o_rsp_valid and o_rsp_data=2 stable. A queued write to addr 3 is not issued until the handshake.
- Simultaneous push/pop at count 2 -> count stays 2; order of issued addresses matches acceptance order 5,6,7.
- With MEM_SEQ_CNT_EN: 3 writes + 2 reads -> o_wr_count=3, o_rd_count=2.

Source files
------------

// File: rtl/mem_cmd_sequencer_if.sv
// Command, memory-pin and response signals of mem_cmd_sequencer bundled as one interface.
// The sequencer uses the master modport; the memory/command environment uses slave.
interface mem_cmd_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic                  i_cmd_wr;
  logic [ADDR_WIDTH-1:0] i_cmd_addr;
  logic [DATA_WIDTH-1:0] i_cmd_data;

  logic                  o_EN;
  logic [ADDR_WIDTH-1:0] o_address;
  logic [DATA_WIDTH-1:0] o_data_in;
  logic [DATA_WIDTH-1:0] i_data_out;

  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_data;

  logic                  o_busy;

  modport master (
    input  i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_data, i_data_out, i_rsp_ready,
    output o_cmd_ready, o_EN, o_address, o_data_in, o_rsp_valid, o_rsp_data, o_busy
  );

  modport slave (
    output i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_data, i_data_out, i_rsp_ready,
    input  o_cmd_ready, o_EN, o_address, o_data_in, o_rsp_valid, o_rsp_data, o_busy
  );

endinterface

// File: rtl/mem_cmd_sequencer.sv
// Buffers write/read commands in a FIFO and issues them in order to a single-port memory.
// Define MEM_SEQ_CNT_EN to add saturating write/read-response counters (o_wr_count/o_rd_count).
module mem_cmd_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mem_cmd_sequencer_if.master  bus
`ifdef MEM_SEQ_CNT_EN
  ,
  output logic [15:0]          o_wr_count,
  output logic [15:0]          o_rd_count
`endif
);

  localparam int PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_WAIT,
    RSP
  } state_e;

  state_e                state_q, state_d;

  logic                  fifoWr_q   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifoAddr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifoData_q [FIFO_DEPTH];

  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  push;
  logic                  pop;
  logic                  fifoEmpty;
  logic                  fifoFull;
  logic                  headWr;
  logic [ADDR_WIDTH-1:0] headAddr;
  logic [DATA_WIDTH-1:0] headData;

  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] dataIn_q, dataIn_d;
  logic                  rspValid_q, rspValid_d;
  logic [DATA_WIDTH-1:0] rspData_q, rspData_d;
  logic [LAT_W-1:0]      latCnt_q, latCnt_d;

  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CNT_W'(FIFO_DEPTH));
  assign push      = bus.i_cmd_valid && !fifoFull;

  assign headWr    = fifoWr_q[rdPtr_q];
  assign headAddr  = fifoAddr_q[rdPtr_q];
  assign headData  = fifoData_q[rdPtr_q];

  // Entry storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifoWr_q[wrPtr_q]   <= bus.i_cmd_wr;
      fifoAddr_q[wrPtr_q] <= bus.i_cmd_addr;
      fifoData_q[wrPtr_q] <= bus.i_cmd_data;
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    en_d       = 1'b0;
    address_d  = address_q;
    dataIn_d   = dataIn_q;
    rspValid_d = rspValid_q;
    rspData_d  = rspData_q;
    latCnt_d   = latCnt_q;

    case (state_q)
      // IDLE and WR share the dispatch path so back-to-back writes issue every cycle.
      IDLE, WR: begin
        state_d = IDLE;
        if (!fifoEmpty) begin
          pop       = 1'b1;
          address_d = headAddr;
          latCnt_d  = '0;
          if (headWr) begin
            state_d  = WR;
            en_d     = 1'b1;
            dataIn_d = headData;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (latCnt_q == LAT_W'(RD_LATENCY)) begin
          rspData_d  = bus.i_data_out;
          rspValid_d = 1'b1;
          state_d    = RSP;
        end else begin
          latCnt_d = latCnt_q + LAT_W'(1);
        end
      end

      RSP: begin
        if (bus.i_rsp_ready) begin
          rspValid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      en_q       <= 1'b0;
      address_q  <= '0;
      dataIn_q   <= '0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      latCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      en_q       <= en_d;
      address_q  <= address_d;
      dataIn_q   <= dataIn_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      latCnt_q   <= latCnt_d;
    end
  end

  assign bus.o_cmd_ready = !fifoFull;
  assign bus.o_EN        = en_q;
  assign bus.o_address   = address_q;
  assign bus.o_data_in   = dataIn_q;
  assign bus.o_rsp_valid = rspValid_q;
  assign bus.o_rsp_data  = rspData_q;
  assign bus.o_busy      = !fifoEmpty || (state_q != IDLE);

`ifdef MEM_SEQ_CNT_EN
  logic [15:0] wrCount_q;
  logic [15:0] rdCount_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wrCount_q <= '0;
      rdCount_q <= '0;
    end else begin
      if ((state_q == WR) && (wrCount_q != 16'hFFFF)) begin
        wrCount_q <= wrCount_q + 16'd1;
      end
      if ((state_q == RSP) && bus.i_rsp_ready && (rdCount_q != 16'hFFFF)) begin
        rdCount_q <= rdCount_q + 16'd1;
      end
    end
  end

  assign o_wr_count = wrCount_q;
  assign o_rd_count = rdCount_q;
`endif

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Self-checking bench for mem_cmd_sequencer: directed scenarios plus random traffic
// scored against an in-order command model with its own reference memory image.
module tb_mem_cmd_sequencer;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int RD_LATENCY = 1;
  localparam int MEM_WORDS  = 1 << ADDR_WIDTH;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wrTxn_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mem_cmd_sequencer_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

`ifdef MEM_SEQ_CNT_EN
  logic [15:0] wrCount;
  logic [15:0] rdCount;
`endif

  mem_cmd_sequencer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .RD_LATENCY(RD_LATENCY)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
`ifdef MEM_SEQ_CNT_EN
    ,
    .o_wr_count(wrCount),
    .o_rd_count(rdCount)
`endif
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;

  logic [DATA_WIDTH-1:0] mem    [MEM_WORDS];
  logic [DATA_WIDTH-1:0] refMem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rdPipe [RD_LATENCY];
  wrTxn_t                expWrQ[$];
  logic [DATA_WIDTH-1:0] expRspQ[$];

  // Memory model: synchronous read through a RD_LATENCY-deep pipe, write on o_EN.
  always @(posedge clk) begin
    rdPipe[0] <= mem[bus.o_address];
    for (int i = 1; i < RD_LATENCY; i++) begin
      rdPipe[i] <= rdPipe[i-1];
    end
    if (bus.o_EN) begin
      mem[bus.o_address] = bus.o_data_in;
    end
  end
  assign bus.i_data_out = rdPipe[RD_LATENCY-1];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic wr,
                               input logic [ADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] data);
    bus.i_cmd_valid = valid;
    bus.i_cmd_wr    = wr;
    bus.i_cmd_addr  = addr;
    bus.i_cmd_data  = data;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    applyStimulus(1'b0, 1'b0, '0, '0);
    bus.i_rsp_ready = 1'b1;
    for (int i = 0; i < 200 && bus.o_busy; i++) begin
      waitCycles(1);
    end
    checkOutput(tag, bus.o_busy, 0);
    waitCycles(1);
  endtask

  // Discarded commands never reach memory, so the reference image resyncs to it.
  task automatic flushModel();
    expWrQ.delete();
    expRspQ.delete();
    for (int i = 0; i < MEM_WORDS; i++) begin
      refMem[i] = mem[i];
    end
  endtask

  // Reference model: commands take effect in acceptance order, so a read's
  // answer is the memory image after all earlier accepted writes.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.i_cmd_valid && bus.o_cmd_ready) begin
        if (bus.i_cmd_wr) begin
          refMem[bus.i_cmd_addr] = bus.i_cmd_data;
          expWrQ.push_back('{addr: bus.i_cmd_addr, data: bus.i_cmd_data});
        end else begin
          expRspQ.push_back(refMem[bus.i_cmd_addr]);
        end
      end
      if (bus.o_EN) begin
        checkOutput("wr_expected", expWrQ.size() != 0, 1);
        if (expWrQ.size() != 0) begin
          wrTxn_t t;
          t = expWrQ.pop_front();
          checkOutput("wr_addr", bus.o_address, t.addr);
          checkOutput("wr_data", bus.o_data_in, t.data);
        end
      end
      if (bus.o_rsp_valid && bus.i_rsp_ready) begin
        checkOutput("rsp_expected", expRspQ.size() != 0, 1);
        if (expRspQ.size() != 0) begin
          checkOutput("rsp_data", bus.o_rsp_data, expRspQ.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i]    = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      refMem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    bus.i_rsp_ready = 1'b1;

    // Reset values.
    waitCycles(1);
    checkOutput("rst_en", bus.o_EN, 0);
    checkOutput("rst_address", bus.o_address, 0);
    checkOutput("rst_data_in", bus.o_data_in, 0);
    checkOutput("rst_rsp_valid", bus.o_rsp_valid, 0);
    checkOutput("rst_rsp_data", bus.o_rsp_data, 0);
    checkOutput("rst_busy", bus.o_busy, 0);
    waitCycles(1);
    rst = 1'b0;
    #1;
    checkOutput("rst_ready", bus.o_cmd_ready, 1);

    // Reset during the second of three queued writes.
    applyStimulus(1'b1, 1'b1, 8'd10, 32'h10);
    waitCycles(1);
    checkOutput("midrst_no_en_yet", bus.o_EN, 0);
    applyStimulus(1'b1, 1'b1, 8'd11, 32'h11);
    waitCycles(1);
    checkOutput("midrst_wr0_en", bus.o_EN, 1);
    checkOutput("midrst_wr0_addr", bus.o_address, 10);
    applyStimulus(1'b1, 1'b1, 8'd12, 32'h12);
    waitCycles(1);
    checkOutput("midrst_wr1_addr", bus.o_address, 11);
    applyStimulus(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_en_drop", bus.o_EN, 0);
    checkOutput("midrst_busy", bus.o_busy, 0);
    waitCycles(1);
    rst = 1'b0;
    flushModel();
    #1;
    checkOutput("midrst_ready", bus.o_cmd_ready, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("midrst_quiet_en", bus.o_EN, 0);
      checkOutput("midrst_quiet_busy", bus.o_busy, 0);
      waitCycles(1);
    end
    checkOutput("midrst_mem10", mem[10], 32'h10);
    checkOutput("midrst_mem11_untouched", mem[11], (11 * 32'h0101_0101) ^ 32'hA5A5_0000);

`ifdef MEM_SEQ_CNT_EN
    checkOutput("cnt_wr_reset", wrCount, 0);
    checkOutput("cnt_rd_reset", rdCount, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(20 + i), 32'(100 + i));
      waitCycles(1);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(20 + i), '0);
      waitCycles(1);
    end
    drain("cnt_drain");
    checkOutput("cnt_wr", wrCount, 3);
    checkOutput("cnt_rd", rdCount, 2);
`endif

    // Write, write, read with exact issue timing.
    applyStimulus(1'b1, 1'b1, 8'd1, 32'd1);
    waitCycles(1);
    checkOutput("wtr_en_lat", bus.o_EN, 0);
    applyStimulus(1'b1, 1'b1, 8'd2, 32'd2);
    waitCycles(1);
    checkOutput("wtr_w1_en", bus.o_EN, 1);
    checkOutput("wtr_w1_addr", bus.o_address, 1);
    checkOutput("wtr_w1_data", bus.o_data_in, 1);
    applyStimulus(1'b1, 1'b0, 8'd1, '0);
    waitCycles(1);
    checkOutput("wtr_w2_en", bus.o_EN, 1);
    checkOutput("wtr_w2_addr", bus.o_address, 2);
    applyStimulus(1'b0, 1'b0, '0, '0);
    waitCycles(1);
    checkOutput("wtr_rd_en", bus.o_EN, 0);
    checkOutput("wtr_rd_addr", bus.o_address, 1);
    waitCycles(1);
    checkOutput("wtr_rsp_early", bus.o_rsp_valid, 0);
    waitCycles(1);
    checkOutput("wtr_rsp_valid", bus.o_rsp_valid, 1);
    checkOutput("wtr_rsp_data", bus.o_rsp_data, 1);
    drain("wtr_drain");

    // Full FIFO behind a stalled read response.
    bus.i_rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'd1, '0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, '0, '0);
    waitCycles(3);
    checkOutput("full_rsp_stalled", bus.o_rsp_valid, 1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 8'(30 + k), 32'(k));
      checkOutput("full_ready_pre", bus.o_cmd_ready, 1);
      waitCycles(1);
    end
    checkOutput("full_ready_after4", bus.o_cmd_ready, 0);
    applyStimulus(1'b1, 1'b1, 8'd34, 32'd4);
    for (int k = 0; k < 3; k++) begin
      waitCycles(1);
      checkOutput("full_ready_held", bus.o_cmd_ready, 0);
      checkOutput("full_no_issue", bus.o_EN, 0);
    end
    bus.i_rsp_ready = 1'b1;
    waitCycles(1);
    checkOutput("full_ready_post_hs", bus.o_cmd_ready, 0);
    checkOutput("full_rsp_drop", bus.o_rsp_valid, 0);
    waitCycles(1);
    checkOutput("full_ready_post_pop", bus.o_cmd_ready, 1);
    checkOutput("full_first_wr_addr", bus.o_address, 30);
    waitCycles(1);
    drain("full_drain");

    // Response backpressure holds data and blocks the queued write.
    bus.i_rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'd2, '0);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 8'd3, 32'd3);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, '0, '0);
    waitCycles(2);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_rsp_valid", bus.o_rsp_valid, 1);
      checkOutput("bp_rsp_data", bus.o_rsp_data, 2);
      checkOutput("bp_no_issue", bus.o_EN, 0);
      waitCycles(1);
    end
    bus.i_rsp_ready = 1'b1;
    waitCycles(1);
    checkOutput("bp_post_hs_en", bus.o_EN, 0);
    checkOutput("bp_post_hs_valid", bus.o_rsp_valid, 0);
    waitCycles(1);
    checkOutput("bp_wr_en", bus.o_EN, 1);
    checkOutput("bp_wr_addr", bus.o_address, 3);
    checkOutput("bp_wr_data", bus.o_data_in, 3);
    drain("bp_drain");

    // Push and pop together with two entries queued.
    bus.i_rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'd3, '0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, '0, '0);
    waitCycles(2);
    applyStimulus(1'b1, 1'b1, 8'd5, 32'd5);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 8'd6, 32'd6);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, '0, '0);
    bus.i_rsp_ready = 1'b1;
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 8'd7, 32'd7);
    waitCycles(1);
    checkOutput("pp_ready", bus.o_cmd_ready, 1);
    checkOutput("pp_addr5", bus.o_address, 5);
    applyStimulus(1'b0, 1'b0, '0, '0);
    waitCycles(1);
    checkOutput("pp_addr6", bus.o_address, 6);
    checkOutput("pp_en6", bus.o_EN, 1);
    waitCycles(1);
    checkOutput("pp_addr7", bus.o_address, 7);
    checkOutput("pp_en7", bus.o_EN, 1);
    waitCycles(1);
    checkOutput("pp_idle_en", bus.o_EN, 0);
    drain("pp_drain");

    // Random traffic with random response backpressure.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)),
                    8'($urandom_range(15)), 32'($urandom));
      bus.i_rsp_ready = ($urandom_range(9) < 7);
      waitCycles(1);
    end
    drain("rand_drain");
    checkOutput("rand_wr_q_empty", expWrQ.size(), 0);
    checkOutput("rand_rsp_q_empty", expRspQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
